// File: rtl/crc_err_checker.sv
// crc_err_checker: receive-side CRC checker for the error-injection path.
// Recomputes the CRC of each frame in a pipelined datapath and flags frames
// whose CRC differs from the received checksum. It also keeps saturating
// detection-statistics counters.
// CRC: init 0, no reflection, no final XOR, shifted MSB first from data_i[DATA_WIDTH-1].
// Latency: valid_i sampled at edge N -> valid_o high after edge N+PIPE_STAGES+1.
// Optional feature macro: CRC_CHK_CAPTURE_EN. It adds capture of the first escaped frame.
// Ports:
//   clk, rst_n (synchronous, active-low)
//   valid_i, data_i, checksum_i, corrupted_i : frame input, one per cycle
//   clear_i                                   : synchronous clear of counters/capture
//   valid_o, error_o, corrupted_o             : per-frame result
//   pkt_cnt_o, det_cnt_o, miss_cnt_o, false_cnt_o : saturating statistics
//   miss_seen_o, miss_data_o, miss_checksum_o : first escaped frame (capture build only)
module crc_err_checker #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned CRC_WIDTH = 32,
    parameter logic [CRC_WIDTH-1:0] POLY = CRC_WIDTH'(32'h04C11DB7),
    parameter int unsigned PIPE_STAGES = 4,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [CRC_WIDTH-1:0]  checksum_i,
    input  logic                  corrupted_i,
    input  logic                  clear_i,
    output logic                  valid_o,
    output logic                  error_o,
    output logic                  corrupted_o,
    output logic [CNT_WIDTH-1:0]  pkt_cnt_o,
    output logic [CNT_WIDTH-1:0]  det_cnt_o,
    output logic [CNT_WIDTH-1:0]  miss_cnt_o,
    output logic [CNT_WIDTH-1:0]  false_cnt_o
`ifdef CRC_CHK_CAPTURE_EN
    ,
    output logic                  miss_seen_o,
    output logic [DATA_WIDTH-1:0] miss_data_o,
    output logic [CRC_WIDTH-1:0]  miss_checksum_o
`endif
);

    localparam int unsigned CHUNK = DATA_WIDTH / PIPE_STAGES;
    localparam int unsigned REM_N = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;

    // Fold one chunk into the running CRC, MSB first.
    function automatic logic [CRC_WIDTH-1:0] crc_fold(input logic [CRC_WIDTH-1:0] crc_in,
                                                      input logic [CHUNK-1:0] chunk);
        logic [CRC_WIDTH-1:0] c;
        logic fb;
        c = crc_in;
        for (int i = int'(CHUNK) - 1; i >= 0; i--) begin
            fb = c[CRC_WIDTH-1] ^ chunk[i];
            c  = {c[CRC_WIDTH-2:0], 1'b0};
            if (fb) c = c ^ POLY;
        end
        return c;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Input capture register
    logic                  ir_vld;
    logic [DATA_WIDTH-1:0] ir_dat;
    logic [CRC_WIDTH-1:0]  ir_chk;
    logic                  ir_cor;

    always_ff @(posedge clk) begin
        if (!rst_n) ir_vld <= 1'b0;
        else        ir_vld <= valid_i;
    end

    always_ff @(posedge clk) begin
        ir_dat <= data_i;
        ir_chk <= checksum_i;
        ir_cor <= corrupted_i;
    end

    // CRC pipeline state; rem_q holds only the not-yet-folded payload (consumed bits shift out as zeros)
    logic [PIPE_STAGES-1:0] vld_q;
    logic [PIPE_STAGES-1:0] cor_q;
    logic [CRC_WIDTH-1:0]   crc_q [PIPE_STAGES];
    logic [CRC_WIDTH-1:0]   chk_q [PIPE_STAGES];
    logic [DATA_WIDTH-1:0]  rem_q [REM_N];

    logic [PIPE_STAGES-1:0] in_vld;
    logic [PIPE_STAGES-1:0] in_cor;
    logic [CRC_WIDTH-1:0]   in_crc [PIPE_STAGES];
    logic [CRC_WIDTH-1:0]   in_chk [PIPE_STAGES];
    logic [DATA_WIDTH-1:0]  in_dat [PIPE_STAGES];

    // Stage input selection: stage 0 from the input register, others from the previous stage
    always_comb begin
        in_vld[0] = ir_vld;
        in_cor[0] = ir_cor;
        in_crc[0] = '0;
        in_chk[0] = ir_chk;
        in_dat[0] = ir_dat;
        for (int k = 1; k < int'(PIPE_STAGES); k++) begin
            in_vld[k] = vld_q[k-1];
            in_cor[k] = cor_q[k-1];
            in_crc[k] = crc_q[k-1];
            in_chk[k] = chk_q[k-1];
            in_dat[k] = rem_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= in_vld;
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(PIPE_STAGES); k++) begin
            crc_q[k] <= crc_fold(in_crc[k], in_dat[k][DATA_WIDTH-1 -: CHUNK]);
            chk_q[k] <= in_chk[k];
        end
        cor_q <= in_cor;
        for (int k = 0; k < int'(PIPE_STAGES) - 1; k++) begin
            rem_q[k] <= in_dat[k] << CHUNK;
        end
    end

    // Compare stage
    logic mismatch;
    assign mismatch = (crc_q[PIPE_STAGES-1] != chk_q[PIPE_STAGES-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_o     <= 1'b0;
            error_o     <= 1'b0;
            corrupted_o <= 1'b0;
        end else begin
            valid_o     <= vld_q[PIPE_STAGES-1];
            error_o     <= mismatch;
            corrupted_o <= cor_q[PIPE_STAGES-1];
        end
    end

    // Statistics; clear takes priority over a result presented in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            pkt_cnt_o   <= '0;
            det_cnt_o   <= '0;
            miss_cnt_o  <= '0;
            false_cnt_o <= '0;
        end else if (valid_o) begin
            pkt_cnt_o <= sat_inc(pkt_cnt_o);
            if (corrupted_o && error_o)   det_cnt_o   <= sat_inc(det_cnt_o);
            if (corrupted_o && !error_o)  miss_cnt_o  <= sat_inc(miss_cnt_o);
            if (!corrupted_o && error_o)  false_cnt_o <= sat_inc(false_cnt_o);
        end
    end

`ifdef CRC_CHK_CAPTURE_EN
    // Full payload/checksum copy travelling alongside the CRC pipeline
    logic [DATA_WIDTH-1:0] dat_q [PIPE_STAGES];
    logic [DATA_WIDTH-1:0] cmp_dat_q;
    logic [CRC_WIDTH-1:0]  cmp_chk_q;

    always_ff @(posedge clk) begin
        dat_q[0] <= ir_dat;
        for (int k = 1; k < int'(PIPE_STAGES); k++) begin
            dat_q[k] <= dat_q[k-1];
        end
        cmp_dat_q <= dat_q[PIPE_STAGES-1];
        cmp_chk_q <= chk_q[PIPE_STAGES-1];
    end

    // Latch only the first escaped frame since reset/clear
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            miss_seen_o     <= 1'b0;
            miss_data_o     <= '0;
            miss_checksum_o <= '0;
        end else if (valid_o && corrupted_o && !error_o && !miss_seen_o) begin
            miss_seen_o     <= 1'b1;
            miss_data_o     <= cmp_dat_q;
            miss_checksum_o <= cmp_chk_q;
        end
    end
`endif

endmodule

// File: tb/tb_crc_err_checker.sv
// Self-checking bench for crc_err_checker with a scoreboard of expected results.
module tb_crc_err_checker;

    localparam int unsigned DW  = 512;
    localparam int unsigned CW  = 32;
    localparam int unsigned PS  = 4;
    localparam int unsigned CNW = 32;
    localparam int unsigned SCW = 4;
    localparam logic [CW-1:0] POLY_REF = 32'h04C11DB7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic [CW-1:0] checksum_i = '0;
    logic          corrupted_i = 1'b0;
    logic          clear_i = 1'b0;

    logic           valid_o, error_o, corrupted_o;
    logic [CNW-1:0] pkt_cnt_o, det_cnt_o, miss_cnt_o, false_cnt_o;
    logic           s_valid, s_error, s_corrupted;
    logic [SCW-1:0] s_pkt, s_det, s_miss, s_false;
`ifdef CRC_CHK_CAPTURE_EN
    logic          miss_seen_o, s_seen;
    logic [DW-1:0] miss_data_o, s_mdata;
    logic [CW-1:0] miss_checksum_o, s_mchk;
`endif

    always #5 clk = ~clk;

    crc_err_checker #(.DATA_WIDTH(DW), .CRC_WIDTH(CW), .POLY(POLY_REF),
                      .PIPE_STAGES(PS), .CNT_WIDTH(CNW)) u_dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i),
        .checksum_i(checksum_i), .corrupted_i(corrupted_i), .clear_i(clear_i),
        .valid_o(valid_o), .error_o(error_o), .corrupted_o(corrupted_o),
        .pkt_cnt_o(pkt_cnt_o), .det_cnt_o(det_cnt_o), .miss_cnt_o(miss_cnt_o),
        .false_cnt_o(false_cnt_o)
`ifdef CRC_CHK_CAPTURE_EN
        , .miss_seen_o(miss_seen_o), .miss_data_o(miss_data_o), .miss_checksum_o(miss_checksum_o)
`endif
    );

    // Narrow-counter instance for saturation; never cleared
    crc_err_checker #(.DATA_WIDTH(DW), .CRC_WIDTH(CW), .POLY(POLY_REF),
                      .PIPE_STAGES(PS), .CNT_WIDTH(SCW)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i),
        .checksum_i(checksum_i), .corrupted_i(corrupted_i), .clear_i(1'b0),
        .valid_o(s_valid), .error_o(s_error), .corrupted_o(s_corrupted),
        .pkt_cnt_o(s_pkt), .det_cnt_o(s_det), .miss_cnt_o(s_miss), .false_cnt_o(s_false)
`ifdef CRC_CHK_CAPTURE_EN
        , .miss_seen_o(s_seen), .miss_data_o(s_mdata), .miss_checksum_o(s_mchk)
`endif
    );

    typedef struct {
        logic          err;
        logic          cor;
        logic [DW-1:0] dat;
        logic [CW-1:0] chk;
        int            cap;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_valid = 0;
    int   run = 0;
    int   last_run = 0;

    // Reference model state
    logic [CNW-1:0] m_pkt = '0, m_det = '0, m_miss = '0, m_false = '0;
    logic [SCW-1:0] m_sat = '0;
    logic           m_seen = 1'b0;
    logic [DW-1:0]  m_mdat = '0;
    logic [CW-1:0]  m_mchk = '0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] ref_crc(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        c = '0;
        for (int i = int'(DW) - 1; i >= 0; i--) begin
            c = (c[CW-1] ^ d[i]) ? ({c[CW-2:0], 1'b0} ^ POLY_REF) : {c[CW-2:0], 1'b0};
        end
        return c;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expectations when a result appears and advances the counter model
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            m_pkt = '0; m_det = '0; m_miss = '0; m_false = '0; m_sat = '0;
            m_seen = 1'b0; m_mdat = '0; m_mchk = '0;
            run = 0;
        end else begin
            if (valid_o) begin
                n_valid++;
                run++;
                if (sb.size() == 0) begin
                    check("unexpected_valid", DW'(valid_o), DW'(1'b0));
                end else begin
                    e = sb.pop_front();
                    check("error_o", DW'(error_o), DW'(e.err));
                    check("corrupted_o", DW'(corrupted_o), DW'(e.cor));
                    check("latency", DW'(cyc), DW'(e.cap + int'(PS) + 1));
                    if (m_sat != '1) m_sat = m_sat + SCW'(1);
                    if (!clear_i) begin
                        m_pkt = m_pkt + CNW'(1);
                        if (e.cor && e.err)  m_det   = m_det + CNW'(1);
                        if (e.cor && !e.err) m_miss  = m_miss + CNW'(1);
                        if (!e.cor && e.err) m_false = m_false + CNW'(1);
                        if (e.cor && !e.err && !m_seen) begin
                            m_seen = 1'b1;
                            m_mdat = e.dat;
                            m_mchk = e.chk;
                        end
                    end
                end
            end else begin
                if (run != 0) last_run = run;
                run = 0;
            end
            if (clear_i) begin
                m_pkt = '0; m_det = '0; m_miss = '0; m_false = '0;
                m_seen = 1'b0; m_mdat = '0; m_mchk = '0;
            end
        end
    end

    // Drive one frame for one edge and record its expected result
    task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic cor);
        exp_t e;
        valid_i = 1'b1;
        data_i = d;
        checksum_i = c;
        corrupted_i = cor;
        e.err = (ref_crc(d) != c);
        e.cor = cor;
        e.dat = d;
        e.chk = c;
        e.cap = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        valid_i = 1'b0;
        while (sb.size() != 0 && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", DW'(sb.size()), DW'(0));
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, ".pkt"}, DW'(pkt_cnt_o), DW'(m_pkt));
        check({tag, ".det"}, DW'(det_cnt_o), DW'(m_det));
        check({tag, ".miss"}, DW'(miss_cnt_o), DW'(m_miss));
        check({tag, ".false"}, DW'(false_cnt_o), DW'(m_false));
        check({tag, ".sat_pkt"}, DW'(s_pkt), DW'(m_sat));
`ifdef CRC_CHK_CAPTURE_EN
        check({tag, ".miss_seen"}, DW'(miss_seen_o), DW'(m_seen));
        check({tag, ".miss_data"}, miss_data_o, m_mdat);
        check({tag, ".miss_chk"}, DW'(miss_checksum_o), DW'(m_mchk));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d, m;
        logic [CW-1:0] c;
        logic cor;
        int n_cor, len, pos, nv_before;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst.valid_o", DW'(valid_o), DW'(0));
        check("rst.error_o", DW'(error_o), DW'(0));
        check("rst.corrupted_o", DW'(corrupted_o), DW'(0));
        check("rst.pkt", DW'(pkt_cnt_o), DW'(0));
        check("rst.det", DW'(det_cnt_o), DW'(0));
        check("rst.miss", DW'(miss_cnt_o), DW'(0));
        check("rst.false", DW'(false_cnt_o), DW'(0));

        // Clean frame
        send('0, '0, 1'b0);
        drain();
        check("clean.pkt", DW'(pkt_cnt_o), DW'(1));
        check_counts("clean");

        // Single bit flip, detected
        d = DW'(1);
        send(d, '0, 1'b1);
        drain();
        check("det.det", DW'(det_cnt_o), DW'(1));
        check_counts("det");

        // Mislabelled frame escapes; second escape (different data) must not overwrite capture
        send('0, '0, 1'b1);
        drain();
        check("miss.miss", DW'(miss_cnt_o), DW'(1));
        check_counts("miss");
        d = DW'(5);
        send(d, ref_crc(d), 1'b1);
        send('0, '0, 1'b1);
        drain();
        check_counts("miss2");

        // Checksum wrong on clean data: false alarm
        send('0, CW'(1), 1'b0);
        drain();
        check("false.false", DW'(false_cnt_o), DW'(1));
        check_counts("false");

        // Clear in the same cycle as a valid result
        send('0, CW'(1), 1'b0);
        valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 clear_i = 1'b1;
        @(posedge clk);
        #1 clear_i = 1'b0;
        drain();
        check("clear.pkt", DW'(pkt_cnt_o), DW'(0));
        check("clear.false", DW'(false_cnt_o), DW'(0));
        check_counts("clear");

        // 100 back-to-back frames with burst errors of at most 32 bits
        n_cor = 0;
        for (int f = 0; f < 100; f++) begin
            for (int w = 0; w < int'(DW / 32); w++) d[w*32 +: 32] = $urandom();
            c = ref_crc(d);
            cor = 1'($urandom_range(0, 1));
            if (cor) begin
                n_cor++;
                len = int'($urandom_range(1, 32));
                pos = int'($urandom_range(0, DW - len));
                m = '0;
                for (int j = 0; j < len; j++)
                    m[pos + j] = (j == 0 || j == len - 1) ? 1'b1 : 1'($urandom_range(0, 1));
                d = d ^ m;
            end
            send(d, c, cor);
        end
        drain();
        check("burst.run_len", DW'(last_run), DW'(100));
        check("burst.pkt", DW'(pkt_cnt_o), DW'(100));
        check("burst.det", DW'(det_cnt_o), DW'(n_cor));
        check("burst.miss", DW'(miss_cnt_o), DW'(0));
        check("burst.false", DW'(false_cnt_o), DW'(0));
        check_counts("burst");

        // 20 clean frames on top: narrow counter stays saturated
        for (int f = 0; f < 20; f++) send('0, '0, 1'b0);
        drain();
        check("sat.pkt", DW'(s_pkt), DW'(15));
        check_counts("sat");

        // Reset for one cycle with 3 frames in flight; valid_i held high during reset
        nv_before = n_valid;
        send(DW'(1), '0, 1'b1);
        send('0, '0, 1'b0);
        send('0, CW'(1), 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        valid_i = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("midrst.no_valid", DW'(n_valid), DW'(nv_before));
        check("midrst.pkt", DW'(pkt_cnt_o), DW'(0));
        check_counts("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
